// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS core memory bridge.
// Access sizes, FSM states and request legality.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUS   = 2'b01,
    ST_RDATA = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Illegal size code or a half/word that straddles its natural boundary.
  function automatic logic req_bad(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    return (size == 2'b11)
        || (size == SIZE_HALF && lo[0])
        || (size == SIZE_WORD && lo != 2'b00);
  endfunction

endpackage

// File: rtl/mips_mem_interface_if.sv
// Core request/response channel and Avalon-MM master channel.
// master modport = side that initiates transfers on that channel.
interface mips_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr,
    output req_size, req_signed, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_size, req_signed, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

interface mips_avl_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_lane_align.sv
// Byte-lane steering between core-side data and the 32-bit bus.
// Pure combinational: byteenable, store replication, load extract/extend.
module mips_lane_align
  import mips_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] ldata
);
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic [31:0] bsh;
  logic [15:0] hsel;

  assign is_byte = size == SIZE_BYTE;
  assign is_half = size == SIZE_HALF;
  assign is_word = size == SIZE_WORD;
  assign bsh     = rdata >> {addr_lo, 3'b000};
  assign hsel    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    byteenable = 4'b0000;
    writedata  = 32'h0;
    ldata      = 32'h0;
    unique case (1'b1)
      is_byte: begin
        byteenable = 4'b0001 << addr_lo;
        writedata  = {4{wdata[7:0]}};
        ldata      = {{24{sign_ext & bsh[7]}}, bsh[7:0]};
      end
      is_half: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
        ldata      = {{16{sign_ext & hsel[15]}}, hsel};
      end
      is_word: begin
        byteenable = 4'b1111;
        writedata  = wdata;
        ldata      = rdata;
      end
      default: begin
        byteenable = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mips_mem_interface.sv
// Single-outstanding load/store bridge from the core to Avalon-MM.
// Request is latched on accept; core inputs are ignored until IDLE.
module mips_mem_interface
  import mips_bus_pkg::*;
#(
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  mips_core_if.slave        core,
  mips_avl_if.master        avl,
  output logic [WAIT_W-1:0] wait_cycles
);
  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic        accept;
  logic        bad;
  logic        in_bus;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] ld;

  assign in_bus = state_q == ST_BUS;
  assign accept = (state_q == ST_IDLE) && core.req_valid;
  assign bad    = req_bad(core.req_size, core.req_addr[1:0]);

  mips_lane_align u_align (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .sign_ext   (signed_q),
    .wdata      (wdata_q),
    .rdata      (avl.readdata),
    .byteenable (be),
    .writedata  (wd),
    .ldata      (ld)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (core.req_valid) state_d = bad ? ST_RESP : ST_BUS;
      end
      ST_BUS: begin
        if (!avl.waitrequest) state_d = write_q ? ST_RESP : ST_RDATA;
      end
      ST_RDATA: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    core.req_ready  = state_q == ST_IDLE;
    core.resp_valid = state_q == ST_RESP;
    avl.read        = in_bus && !write_q;
    avl.write       = in_bus && write_q;
    avl.address     = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
    avl.byteenable  = in_bus ? be : 4'b0000;
    avl.writedata   = in_bus ? wd : 32'h0;
  end

  always_comb begin
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    wait_d       = wait_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    if (accept) begin
      write_d  = core.req_write;
      addr_d   = core.req_addr;
      size_d   = core.req_size;
      signed_d = core.req_signed;
      wdata_d  = core.req_wdata;
      wait_d   = '0;
      if (bad) begin
        resp_err_d   = 1'b1;
        resp_rdata_d = 32'h0;
      end
    end
    if (in_bus) begin
      if (avl.waitrequest) begin
        if (wait_q != '1) wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
      end else if (write_q) begin
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
      end
    end
    // readdata is valid only in the cycle after the read completes
    if (state_q == ST_RDATA) begin
      resp_err_d   = 1'b0;
      resp_rdata_d = ld;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q      <= 1'b0;
      addr_q       <= 32'h0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      wdata_q      <= 32'h0;
      wait_q       <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      wait_q       <= wait_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign core.resp_err   = resp_err_q;
  assign core.resp_rdata = resp_rdata_q;
  assign wait_cycles     = wait_q;

endmodule
